bin_to_bcd: RTL and testbench



---
 rtl/bin_to_bcd.sv | 109 ++++++++++
 tb/tb_bin_to_bcd.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one iteration per clock.
// Start/busy/done handshake; result held until the next completion.
module bin_to_bcd #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] bin_q;
    logic [BW-1:0]    work_q;
    logic             acc_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [BW-1:0]    bcd_q;
    logic             ovf_q;

    logic [BW-1:0]    adj_d;
    logic [BW-1:0]    work_d;
    logic [WIDTH-1:0] bin_d;
    logic [CW-1:0]    cnt_d;
    logic             carry_d;
    logic             last_d;

    // Add 3 to every digit >= 5, all digits in parallel from pre-shift values
    always_comb begin
        adj_d = work_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (work_q[4*k +: 4] >= 4'd5) begin
                adj_d[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // One left shift of {BCD, binary}; the bit leaving the top digit is a lost carry
    always_comb begin
        work_d  = {adj_d[BW-2:0], bin_q[WIDTH-1]};
        carry_d = adj_d[BW-1];
        bin_d   = bin_q << 1;
        cnt_d   = cnt_q + CW'(1);
        last_d  = (cnt_q == CW'(WIDTH - 1));
    end

    // Control FSM and all working/output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            work_q  <= '0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_q   <= bin;
                        work_q  <= '0;
                        acc_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bin_q  <= bin_d;
                    work_q <= work_d;
                    acc_q  <= acc_q | carry_d;
                    cnt_q  <= cnt_d;
                    if (last_d) begin
                        bcd_q   <= work_d;
                        ovf_q   <= acc_q | carry_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed bench for bin_to_bcd: 3-digit, 2-digit (overflow) and 1-bit instances.
`timescale 1ns/1ps
module tb_bin_to_bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic        start3, start2, start1;
    logic [7:0]  bin3, bin2;
    logic        bin1;
    logic        busy3, done3, ovf3;
    logic        busy2, done2, ovf2;
    logic        busy1, done1, ovf1;
    logic [11:0] bcd3;
    logic [7:0]  bcd2;
    logic [3:0]  bcd1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
    } vec3_t;

    typedef struct {
        logic [7:0] bin;
        logic [7:0] bcd;
        logic       ovf;
    } vec2_t;

    vec3_t v3[8];
    vec2_t v2[5];

    always #5 clk = ~clk;

    bin_to_bcd #(.WIDTH(8), .DIGITS(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .bin(bin3),
        .busy(busy3), .done(done3), .bcd(bcd3), .overflow(ovf3));

    bin_to_bcd #(.WIDTH(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2));

    bin_to_bcd #(.WIDTH(1), .DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .bin(bin1),
        .busy(busy1), .done(done1), .bcd(bcd1), .overflow(ovf1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // One conversion on the 3-digit instance with latency/busy/pulse checks
    task automatic run3(input logic [7:0] v, input logic [11:0] exp);
        int n;
        int nbusy;
        @(negedge clk);
        start3 = 1'b1;
        bin3   = v;
        @(posedge clk); #1;
        start3 = 1'b0;
        bin3   = ~v;
        n     = 0;
        nbusy = 0;
        while (!done3 && n < 20) begin
            if (busy3) nbusy++;
            @(posedge clk); #1;
            n++;
        end
        check("d3_latency", n, 8);
        check("d3_busy_cycles", nbusy, 8);
        check("d3_bcd", bcd3, exp);
        check("d3_ovf", ovf3, 0);
        check("d3_busy_at_done", busy3, 0);
        @(posedge clk); #1;
        check("d3_done_pulse", done3, 0);
        check("d3_bcd_hold", bcd3, exp);
    endtask

    // One conversion on the 2-digit instance
    task automatic run2(input logic [7:0] v, input logic [7:0] exp, input logic eovf);
        int n;
        @(negedge clk);
        start2 = 1'b1;
        bin2   = v;
        @(posedge clk); #1;
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("d2_latency", n, 8);
        check("d2_bcd", bcd2, exp);
        check("d2_ovf", ovf2, eovf);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int ndone;
        logic got;

        v3[0] = '{8'd0,   12'h000};
        v3[1] = '{8'd255, 12'h255};
        v3[2] = '{8'd99,  12'h099};
        v3[3] = '{8'd10,  12'h010};
        v3[4] = '{8'd100, 12'h100};
        v3[5] = '{8'd128, 12'h128};
        v3[6] = '{8'd9,   12'h009};
        v3[7] = '{8'd1,   12'h001};

        v2[0] = '{8'd100, 8'h00, 1'b1};
        v2[1] = '{8'd199, 8'h99, 1'b1};
        v2[2] = '{8'd42,  8'h42, 1'b0};
        v2[3] = '{8'd99,  8'h99, 1'b0};
        v2[4] = '{8'd255, 8'h55, 1'b1};

        rst = 1'b1;
        start3 = 1'b0; start2 = 1'b0; start1 = 1'b0;
        bin3 = '0; bin2 = '0; bin1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy3, 0);
        check("rst_done", done3, 0);
        check("rst_bcd", bcd3, 0);
        check("rst_ovf", ovf3, 0);
        @(negedge clk);
        rst = 1'b0;

        // Table of single conversions
        for (int i = 0; i < 8; i++) run3(v3[i].bin, v3[i].bcd);
        for (int i = 0; i < 5; i++) run2(v2[i].bin, v2[i].bcd, v2[i].ovf);

        // WIDTH=1: result one edge after the start edge
        @(negedge clk);
        start1 = 1'b1;
        bin1   = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        check("w1_busy", busy1, 1);
        @(posedge clk); #1;
        check("w1_done", done1, 1);
        check("w1_bcd", bcd1, 4'h1);
        check("w1_busy_end", busy1, 0);

        // start held high: sweep 0..255, bin changed while busy
        @(negedge clk);
        start3 = 1'b1;
        bin3   = 8'd0;
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) begin
            n = 0;
            bin3 = 8'(i + 1);
            while (!done3 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check("sweep_latency", n, 8);
            check("sweep_bcd", bcd3, to_bcd(i));
            if (i == 255) start3 = 1'b0;
            @(posedge clk); #1;
            if (i < 255) check("sweep_busy_restart", busy3, 1);
        end
        check("sweep_idle", busy3, 0);

        // start pulsed mid-conversion is ignored
        @(negedge clk);
        start3 = 1'b1;
        bin3   = 8'd123;
        @(posedge clk); #1;
        start3 = 1'b0;
        n   = 0;
        got = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(posedge clk); #1;
            start3 = (k == 3);
            if (k == 3) bin3 = 8'd45;
            if (done3) begin
                got = 1'b1;
                n   = k;
            end
        end
        start3 = 1'b0;
        check("mid_latency", n, 8);
        check("mid_bcd", bcd3, 12'h123);
        check("mid_busy_end", busy3, 0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done3 || busy3) ndone++;
        end
        check("mid_no_second", ndone, 0);

        // Reset mid-conversion of 200
        @(negedge clk);
        start3 = 1'b1;
        bin3   = 8'd200;
        @(posedge clk); #1;
        start3 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", busy3, 0);
        check("abort_done", done3, 0);
        check("abort_bcd", bcd3, 0);
        check("abort_ovf2", ovf2, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done3 || busy3) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run3(8'd7, 12'h007);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
